// File: rtl/vproc_pkg.sv
// Shared types for the vproc memory initiator: client identifiers and small helpers.
package vproc_pkg;

    typedef enum logic {
        MEM_CLIENT_INSTR = 1'b0,
        MEM_CLIENT_DATA  = 1'b1
    } mem_client_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/vproc_mem_id_fifo.sv
// In-order ID FIFO remembering which client owns each outstanding memory request.
// Pointers wrap modulo DEPTH, so any DEPTH >= 1 is supported.
module vproc_mem_id_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1),
    parameter type         elem_t = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  elem_t            data_i,
    input  logic             pop_i,
    output elem_t            data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    elem_t            slots_q [DEPTH];
    elem_t            slots_d [DEPTH];
    logic             full, empty, push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        slots_d = slots_q;
        if (push_ok) begin
            slots_d[wptr_q] = data_i;
            wptr_d          = ptr_inc(wptr_q);
        end
        if (pop_ok) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        slots_q <= slots_d;
    end

    assign data_o  = slots_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/vproc_mem_initiator.sv
// Initiator side of the single-port memory bus: round-robin arbitration of the instruction
// and data clients, one registered request per cycle, in-order response routing.
// Optional performance counters are built when VPROC_MEM_INIT_PERF_EN is defined.
module vproc_mem_initiator
    import vproc_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                ireq_i,
    input  logic [ADDR_W-1:0]   iaddr_i,
    output logic                igy_o,
    output logic                irvalid_o,
    output logic                ierr_o,
    output logic [DATA_W-1:0]   irdata_o,

    input  logic                dreq_i,
    input  logic [ADDR_W-1:0]   daddr_i,
    input  logic                dwe_i,
    input  logic [DATA_W/8-1:0] dbe_i,
    input  logic [DATA_W-1:0]   dwdata_i,
    output logic                dgnt_o,
    output logic                drvalid_o,
    output logic                derr_o,
    output logic [DATA_W-1:0]   drdata_o,

    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic                mem_err_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef VPROC_MEM_INIT_PERF_EN
    ,
    output logic [31:0]         perf_req_cnt_o,
    output logic [31:0]         perf_stall_cnt_o
`endif
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    mem_client_e        rr_ptr_q, rr_ptr_d;
    mem_client_e        gnt_client;
    mem_client_e        head_client;
    logic               gnt_instr, gnt_data, grant;
    logic               can_issue, rsp_hit;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full_unused;

    logic               mem_req_q,   mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic               mem_we_q,    mem_we_d;
    logic [BE_W-1:0]    mem_be_q,    mem_be_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    // The output register counts as outstanding, so a slot frees up only through a response.
    assign can_issue = (fifo_count < CNT_W'(MAX_OUTSTANDING)) | mem_rvalid_i;
    assign rsp_hit   = mem_rvalid_i & ~fifo_empty;

    // Grants are gated by rst_ni so they fall immediately when reset asserts mid-cycle.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (rst_ni && can_issue) begin
            if (ireq_i && dreq_i) begin
                gnt_instr = (rr_ptr_q == MEM_CLIENT_INSTR);
                gnt_data  = (rr_ptr_q == MEM_CLIENT_DATA);
            end else begin
                gnt_instr = ireq_i;
                gnt_data  = dreq_i;
            end
        end
    end

    assign grant      = gnt_instr | gnt_data;
    assign gnt_client = gnt_data ? MEM_CLIENT_DATA : MEM_CLIENT_INSTR;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mem_req_d   = grant;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if (gnt_instr) begin
            rr_ptr_d    = MEM_CLIENT_DATA;
            mem_addr_d  = iaddr_i;
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_wdata_d = '0;
        end else if (gnt_data) begin
            rr_ptr_d    = MEM_CLIENT_INSTR;
            mem_addr_d  = daddr_i;
            mem_we_d    = dwe_i;
            mem_be_d    = dbe_i;
            mem_wdata_d = dwdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= MEM_CLIENT_INSTR;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

    vproc_mem_id_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .CNT_W  (CNT_W),
        .elem_t (mem_client_e)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (gnt_client),
        .pop_i   (rsp_hit),
        .data_o  (head_client),
        .count_o (fifo_count),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty)
    );

    // Responses bypass any register: the head ID steers them in the cycle they arrive.
    always_comb begin
        irvalid_o = rsp_hit & (head_client == MEM_CLIENT_INSTR);
        drvalid_o = rsp_hit & (head_client == MEM_CLIENT_DATA);
        ierr_o    = irvalid_o & mem_err_i;
        derr_o    = drvalid_o & mem_err_i;
        irdata_o  = irvalid_o ? mem_rdata_i : '0;
        drdata_o  = drvalid_o ? mem_rdata_i : '0;
    end

    assign igy_o  = gnt_instr;
    assign dgnt_o = gnt_data;

`ifdef VPROC_MEM_INIT_PERF_EN
    logic [31:0] perf_req_q,   perf_req_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_req_d   = sat_inc32(perf_req_q, grant);
        perf_stall_d = sat_inc32(perf_stall_q, (ireq_i | dreq_i) & ~grant);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_req_q   <= perf_req_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_req_cnt_o   = perf_req_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_vproc_mem_initiator.sv
// Bench for vproc_mem_initiator: a 256 KiB latency-configurable memory model plus a
// queue-based reference of outstanding requests, driven by directed and random steps.
module tb_vproc_mem_initiator;
    import vproc_pkg::*;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ireq_i, dreq_i, dwe_i;
    logic [31:0] iaddr_i, daddr_i, dwdata_i;
    logic [3:0]  dbe_i;
    logic        igy_o, irvalid_o, ierr_o, dgnt_o, drvalid_o, derr_o;
    logic [31:0] irdata_o, drdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
`ifdef VPROC_MEM_INIT_PERF_EN
    logic [31:0] perf_req_cnt_o, perf_stall_cnt_o;
`endif

    always #5 clk = ~clk;

    vproc_mem_initiator #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ireq_i(ireq_i), .iaddr_i(iaddr_i), .igy_o(igy_o),
        .irvalid_o(irvalid_o), .ierr_o(ierr_o), .irdata_o(irdata_o),
        .dreq_i(dreq_i), .daddr_i(daddr_i), .dwe_i(dwe_i), .dbe_i(dbe_i), .dwdata_i(dwdata_i),
        .dgnt_o(dgnt_o), .drvalid_o(drvalid_o), .derr_o(derr_o), .drdata_o(drdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
`ifdef VPROC_MEM_INIT_PERF_EN
        , .perf_req_cnt_o(perf_req_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // External memory (filled by the bus) and the reference's own view of memory.
    bit [31:0] ext_mem [65536];
    bit [31:0] ref_mem [65536];

    typedef struct { int due; bit err; bit [31:0] data; } rsp_t;
    rsp_t rsp_q[$];
    int   lat = 1;
    int   cyc = 0;

    typedef struct { bit is_data; bit err; bit [31:0] data; } out_t;
    out_t out_q[$];
    bit        last_gnt_data = 1'b1;
    bit        exp_req = 1'b0, exp_we = 1'b0;
    bit [31:0] exp_addr = '0, exp_wdata = '0;
    bit [3:0]  exp_be = '0;
    int        gnt_total = 0;
    int        obs_ir = 0, obs_dr = 0, obs_ierr = 0, obs_derr = 0;
    bit        dg_log[$];

    task automatic step();
        bit gi, gd, rv, hit, can, e, is_err, wr;
        out_t h;
        bit [31:0] a, d, wd, rd;
        bit [3:0] be;
        bit [15:0] idx;
        @(negedge clk);
        rv  = mem_rvalid_i;
        hit = rst_ni && rv && (out_q.size() > 0);
        can = rst_ni && ((out_q.size() < MAXO) || rv);
        gi = 1'b0;
        gd = 1'b0;
        if (can) begin
            if (ireq_i && dreq_i) begin
                gi = last_gnt_data;
                gd = !last_gnt_data;
            end else begin
                gi = ireq_i;
                gd = dreq_i;
            end
        end
        if (!rst_ni) exp_req = 1'b0;
        chk("igy", igy_o, gi);
        chk("dgnt", dgnt_o, gd);
        h = hit ? out_q[0] : '{0, 0, 0};
        chk("irvalid", irvalid_o, hit && !h.is_data);
        chk("drvalid", drvalid_o, hit && h.is_data);
        chk("ierr", ierr_o, hit && !h.is_data && h.err);
        chk("derr", derr_o, hit && h.is_data && h.err);
        if (hit && !h.is_data && !h.err) chk("irdata", irdata_o, h.data);
        if (hit && h.is_data && !h.err) chk("drdata", drdata_o, h.data);
        chk("mem_req", mem_req_o, exp_req);
        if (exp_req) begin
            chk("mem_addr", mem_addr_o, exp_addr);
            chk("mem_we", mem_we_o, exp_we);
            chk("mem_be", mem_be_o, exp_be);
            chk("mem_wdata", mem_wdata_o, exp_wdata);
        end
        obs_ir += int'(irvalid_o);
        obs_dr += int'(drvalid_o);
        obs_ierr += int'(ierr_o);
        obs_derr += int'(derr_o);
        dg_log.push_back(dgnt_o);
        // memory side: accept whatever is on the bus this cycle
        if (mem_req_o === 1'b1) begin
            idx = mem_addr_o[17:2];
            is_err = (mem_addr_o > 32'h0003_FFFF);
            rd = is_err ? 32'h0 : ext_mem[idx];
            if (mem_we_o && !is_err)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ext_mem[idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
            rsp_q.push_back('{cyc + lat, is_err, rd});
        end
        // reference: what the coming clock edge does
        if (hit) void'(out_q.pop_front());
        if (gi || gd) begin
            a  = gi ? iaddr_i : daddr_i;
            wr = gd && dwe_i;
            be = gd ? dbe_i : 4'hF;
            wd = gd ? dwdata_i : 32'h0;
            e  = (a > 32'h0003_FFFF);
            d  = e ? 32'h0 : ref_mem[a[17:2]];
            if (wr && !e)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[17:2]][8*b +: 8] = wd[8*b +: 8];
            out_q.push_back('{gd, e, d});
            exp_addr = a;
            exp_we = wr;
            exp_be = be;
            exp_wdata = wd;
            last_gnt_data = gd;
            gnt_total++;
        end
        exp_req = gi || gd;
        if (!rst_ni) begin
            out_q.delete();
            last_gnt_data = 1'b1;
            exp_req = 1'b0;
            gnt_total = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_err_i    = rsp_q[0].err;
            mem_rdata_i  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_err_i    = 1'($urandom);
            mem_rdata_i  = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        ireq_i = 1'b0;
        dreq_i = 1'b0;
        n = 0;
        while ((out_q.size() > 0 || rsp_q.size() > 0) && n < 100) begin
            step();
            n++;
        end
        step();
        chk("drain_timeout", n < 100, 1'b1);
    endtask

    int        b_ir, b_dr, b_ierr, b_derr, g0;
    bit [15:0] dg_pat;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        ireq_i = 1'b1; dreq_i = 1'b1; dwe_i = 1'b0;
        iaddr_i = 32'h0; daddr_i = 32'h0; dwdata_i = 32'h0; dbe_i = 4'h0;
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;

        // reset state, with both clients requesting
        step();
        step();
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_be", mem_be_o, 4'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_irdata", irdata_o, 32'h0);
        chk("rst_drdata", drdata_o, 32'h0);
        rst_ni = 1'b1;
        ireq_i = 1'b0; dreq_i = 1'b0;
        step();

        // both clients held for 8 cycles: I,D,I,D,...
        lat = 2;
        b_ir = obs_ir; b_dr = obs_dr;
        dg_log.delete();
        ireq_i = 1'b1; dreq_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iaddr_i = 32'h1000 + 32'(i * 4);
            daddr_i = 32'h2000 + 32'(i * 4);
            step();
        end
        dg_pat = '0;
        for (int i = 0; i < 8; i++) dg_pat[i] = dg_log[i];
        chk("rr_pattern", dg_pat[7:0], 8'hAA);
        drain();
        chk("rr_i_rsp", obs_ir - b_ir, 4);
        chk("rr_d_rsp", obs_dr - b_dr, 4);

        // single instruction read, latency 1
        lat = 1;
        ext_mem[16'h0040] = 32'hDEAD_BEEF;
        ref_mem[16'h0040] = 32'hDEAD_BEEF;
        b_ir = obs_ir; b_dr = obs_dr;
        ireq_i = 1'b1; iaddr_i = 32'h100;
        step();
        drain();
        chk("ird_count", obs_ir - b_ir, 1);
        chk("ird_no_d", obs_dr - b_dr, 0);

        // data client held with latency 8: four grants, stall, grant alongside first rvalid
        lat = 8;
        dg_log.delete();
        dreq_i = 1'b1; dwe_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            daddr_i = 32'h300 + 32'(i * 4);
            step();
        end
        dg_pat = '0;
        for (int i = 0; i < 10; i++) dg_pat[i] = dg_log[i];
        chk("full_stall", dg_pat[9:0], 10'b10_0000_1111);
        drain();

        // partial write
        lat = 1;
        ext_mem[16'h0010] = 32'hAAAA_AAAA;
        ref_mem[16'h0010] = 32'hAAAA_AAAA;
        b_dr = obs_dr;
        dreq_i = 1'b1; daddr_i = 32'h40; dwe_i = 1'b1; dbe_i = 4'b0011; dwdata_i = 32'h1234_5678;
        step();
        drain();
        dwe_i = 1'b0;
        chk("wr_mem", ext_mem[16'h0010], 32'hAAAA_5678);
        chk("wr_rsp", obs_dr - b_dr, 1);

        // out-of-range read
        b_ierr = obs_ierr; b_derr = obs_derr;
        dreq_i = 1'b1; daddr_i = 32'h0004_0000;
        step();
        drain();
        chk("err_d", obs_derr - b_derr, 1);
        chk("err_i", obs_ierr - b_ierr, 0);

        // random traffic at several latencies
        for (int l = 0; l < 3; l++) begin
            lat = 1 + 2 * l;
            for (int i = 0; i < 150; i++) begin
                ireq_i   = ($urandom_range(0, 9) < 6);
                dreq_i   = ($urandom_range(0, 9) < 6);
                iaddr_i  = $urandom_range(0, 32'h11FFF) << 2;
                daddr_i  = $urandom_range(0, 32'h11FFF) << 2;
                dwe_i    = 1'($urandom);
                dbe_i    = 4'($urandom);
                dwdata_i = $urandom;
                step();
            end
            drain();
        end
        dwe_i = 1'b0;

        // reset with three requests outstanding
        lat = 6;
        ireq_i = 1'b1; dreq_i = 1'b1;
        iaddr_i = 32'h200; daddr_i = 32'h204;
        for (int i = 0; i < 3; i++) step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_igy", igy_o, 1'b0);
        chk("arst_dgnt", dgnt_o, 1'b0);
        chk("arst_mem_req", mem_req_o, 1'b0);
        chk("arst_mem_addr", mem_addr_o, 32'h0);
        chk("arst_mem_be", mem_be_o, 4'h0);
        chk("arst_irvalid", irvalid_o, 1'b0);
        chk("arst_drvalid", drvalid_o, 1'b0);
        step();
        step();
        rst_ni = 1'b1;
        b_ir = obs_ir; b_dr = obs_dr;
        drain();
        chk("late_i", obs_ir - b_ir, 0);
        chk("late_d", obs_dr - b_dr, 0);
        lat = 1;
        ireq_i = 1'b1; iaddr_i = 32'h100;
        g0 = gnt_total;
        step();
        drain();
        chk("post_rst_rsp", obs_ir - b_ir, 1);
`ifdef VPROC_MEM_INIT_PERF_EN
        chk("perf_req", perf_req_cnt_o, 32'(gnt_total));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
